accel_spi_reader: RTL and testbench



---
 rtl/accel_spi_reader.sv | 224 ++++++++++++++++++++++
 tb/tb_accel_spi_reader.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/accel_spi_reader.sv
// SPI master for the ADXL362: enables measurement mode once, then polls XDATA/YDATA
// at a fixed rate and publishes them as a coherent pair with a one-cycle valid strobe.
module accel_spi_reader #(
    parameter int unsigned CLK_DIV        = 4,
    parameter int unsigned POWERUP_CYCLES = 180000,
    parameter int unsigned POLL_CYCLES    = 360000,
    parameter int unsigned CS_GAP         = 8
) (
    input  logic       pixel_clk,
    input  logic       rst_n,
    output logic       spi_sclk,
    output logic       spi_cs_n,
    output logic       spi_mosi,
    input  logic       spi_miso,
    output logic [7:0] accel_data_x,
    output logic [7:0] accel_data_y,
    output logic       accel_valid,
    output logic       cfg_done
);

    localparam int unsigned DIV_W    = 8;
    localparam int unsigned BIT_W    = 5;
    localparam int unsigned WAIT_MAX = (POWERUP_CYCLES > CS_GAP) ? POWERUP_CYCLES : CS_GAP;
    localparam int unsigned CNT_W    = $clog2(WAIT_MAX + 1);
    localparam int unsigned POLL_W   = $clog2(POLL_CYCLES + 1);

    localparam logic [23:0] CFG_FRAME = 24'h0A_2D_02;
    localparam logic [23:0] RDX_FRAME = 24'h0B_08_00;
    localparam logic [23:0] RDY_FRAME = 24'h0B_09_00;

    typedef enum logic [2:0] {
        PWRUP, CFG, GAP_CFG, RD_X, GAP_XY, RD_Y, PUBLISH, WAIT
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [POLL_W-1:0]   poll_q, poll_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [BIT_W-1:0]    bit_q, bit_d;
    logic [23:0]         tx_q, tx_d;
    logic [7:0]          rx_q, rx_d;
    logic [7:0]          shadow_x_q, shadow_x_d;
    logic [7:0]          shadow_y_q, shadow_y_d;
    logic [7:0]          data_x_q, data_x_d;
    logic [7:0]          data_y_q, data_y_d;
    logic                sclk_q, sclk_d;
    logic                cs_n_q, cs_n_d;
    logic                mosi_q, mosi_d;
    logic                valid_q, valid_d;
    logic                cfg_done_q, cfg_done_d;
    logic                xfer_active_c;
    logic                xfer_last_c;
    logic                start_c;
    logic [23:0]         frame_c;

    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= PWRUP;
            cnt_q      <= '0;
            poll_q     <= '0;
            div_q      <= '0;
            bit_q      <= '0;
            tx_q       <= '0;
            rx_q       <= '0;
            shadow_x_q <= '0;
            shadow_y_q <= '0;
            data_x_q   <= '0;
            data_y_q   <= '0;
            sclk_q     <= 1'b0;
            cs_n_q     <= 1'b1;
            mosi_q     <= 1'b0;
            valid_q    <= 1'b0;
            cfg_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            poll_q     <= poll_d;
            div_q      <= div_d;
            bit_q      <= bit_d;
            tx_q       <= tx_d;
            rx_q       <= rx_d;
            shadow_x_q <= shadow_x_d;
            shadow_y_q <= shadow_y_d;
            data_x_q   <= data_x_d;
            data_y_q   <= data_y_d;
            sclk_q     <= sclk_d;
            cs_n_q     <= cs_n_d;
            mosi_q     <= mosi_d;
            valid_q    <= valid_d;
            cfg_done_q <= cfg_done_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        poll_d        = poll_q + POLL_W'(1);
        div_d         = div_q;
        bit_d         = bit_q;
        tx_d          = tx_q;
        rx_d          = rx_q;
        shadow_x_d    = shadow_x_q;
        shadow_y_d    = shadow_y_q;
        data_x_d      = data_x_q;
        data_y_d      = data_y_q;
        sclk_d        = sclk_q;
        cs_n_d        = cs_n_q;
        mosi_d        = mosi_q;
        valid_d       = 1'b0;
        cfg_done_d    = cfg_done_q;
        xfer_last_c   = 1'b0;
        start_c       = 1'b0;
        frame_c       = '0;
        xfer_active_c = (state_q == CFG) || (state_q == RD_X) || (state_q == RD_Y);

        // Bit engine: SCLK toggles every CLK_DIV cycles; sample on rise, shift on fall
        if (xfer_active_c) begin
            if (div_q == DIV_W'(CLK_DIV - 1)) begin
                div_d = '0;
                if (!sclk_q) begin
                    sclk_d = 1'b1;
                    if (bit_q >= BIT_W'(16)) begin
                        rx_d = {rx_q[6:0], spi_miso};
                    end
                end else begin
                    sclk_d = 1'b0;
                    if (bit_q == BIT_W'(23)) begin
                        xfer_last_c = 1'b1;
                        cs_n_d      = 1'b1;
                        mosi_d      = 1'b0;
                    end else begin
                        bit_d  = bit_q + BIT_W'(1);
                        tx_d   = tx_q << 1;
                        mosi_d = tx_q[22];
                    end
                end
            end else begin
                div_d = div_q + DIV_W'(1);
            end
        end

        case (state_q)
            PWRUP: begin
                if (cnt_q == CNT_W'(POWERUP_CYCLES - 1)) begin
                    state_d = CFG;
                    start_c = 1'b1;
                    frame_c = CFG_FRAME;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            CFG: begin
                if (xfer_last_c) begin
                    cfg_done_d = 1'b1;
                    cnt_d      = '0;
                    state_d    = GAP_CFG;
                end
            end
            GAP_CFG, GAP_XY: begin
                if (cnt_q == CNT_W'(CS_GAP - 1)) begin
                    start_c = 1'b1;
                    if (state_q == GAP_CFG) begin
                        state_d = RD_X;
                        frame_c = RDX_FRAME;
                        poll_d  = '0;
                    end else begin
                        state_d = RD_Y;
                        frame_c = RDY_FRAME;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RD_X: begin
                if (xfer_last_c) begin
                    shadow_x_d = rx_q;
                    cnt_d      = '0;
                    state_d    = GAP_XY;
                end
            end
            RD_Y: begin
                if (xfer_last_c) begin
                    shadow_y_d = rx_q;
                    state_d    = PUBLISH;
                end
            end
            PUBLISH: begin
                data_x_d = shadow_x_q;
                data_y_d = shadow_y_q;
                valid_d  = 1'b1;
                state_d  = WAIT;
            end
            WAIT: begin
                if (poll_q == POLL_W'(POLL_CYCLES - 1)) begin
                    state_d = RD_X;
                    start_c = 1'b1;
                    frame_c = RDX_FRAME;
                    poll_d  = '0;
                end
            end
            default: state_d = PWRUP;
        endcase

        // cs_n falls with the first MOSI bit already on the wire
        if (start_c) begin
            cs_n_d = 1'b0;
            sclk_d = 1'b0;
            tx_d   = frame_c;
            mosi_d = frame_c[23];
            div_d  = '0;
            bit_d  = '0;
            rx_d   = '0;
        end
    end

    assign spi_sclk     = sclk_q;
    assign spi_cs_n     = cs_n_q;
    assign spi_mosi     = mosi_q;
    assign accel_data_x = data_x_q;
    assign accel_data_y = data_y_q;
    assign accel_valid  = valid_q;
    assign cfg_done     = cfg_done_q;

endmodule

// File: tb/tb_accel_spi_reader.sv
// Bench for accel_spi_reader: ADXL362 slave model, frame/timing checker and
// a scoreboard matching each published X/Y pair against the values the slave served.
`timescale 1ns/1ps
module tb_accel_spi_reader;

    localparam int unsigned CLK_DIV = 4;
    localparam int unsigned POWERUP = 100;
    localparam int unsigned POLL    = 2000;
    localparam int unsigned CS_GAP  = 8;

    logic       pixel_clk = 1'b0;
    logic       rst_n     = 1'b0;
    logic       spi_sclk, spi_cs_n, spi_mosi;
    logic       spi_miso  = 1'b0;
    logic [7:0] accel_data_x, accel_data_y;
    logic       accel_valid, cfg_done;

    accel_spi_reader #(
        .CLK_DIV(CLK_DIV), .POWERUP_CYCLES(POWERUP), .POLL_CYCLES(POLL), .CS_GAP(CS_GAP)
    ) dut (
        .pixel_clk(pixel_clk), .rst_n(rst_n),
        .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
        .accel_data_x(accel_data_x), .accel_data_y(accel_data_y),
        .accel_valid(accel_valid), .cfg_done(cfg_done)
    );

    always #5 pixel_clk = ~pixel_clk;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int rel_cyc     = 0;
    int valid_cnt   = 0;
    int frames_done = 0;

    // Bench-owned accelerometer register contents
    logic [7:0]  reg_x = 8'h1F;
    logic [7:0]  reg_y = 8'hE3;
    logic        miso_ones = 1'b0;
    logic [15:0] exp_q[$];

    always @(posedge pixel_clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [23:0] exp_frame(input int idx);
        if (idx == 0)          return 24'h0A2D02;
        else if (idx % 2 == 1) return 24'h0B0800;
        else                   return 24'h0B0900;
    endfunction

    // Slave model and bus timing checker
    logic        in_frame = 1'b0, prev_cs = 1'b1, prev_sclk = 1'b0;
    logic        have_gap = 1'b0, have_x = 1'b0, first_fall = 1'b1, period_bad = 1'b0;
    int          frame_idx = 0, rises = 0, falls = 0;
    int          fall_cyc = 0, rise_cyc = 0, x_fall_cyc = 0, sclk_rise_cyc = 0;
    logic [23:0] shreg = '0;
    logic [7:0]  data = '0, served_x = '0, served_y = '0;

    always @(negedge pixel_clk) begin
        if (!rst_n) begin
            in_frame = 1'b0; frame_idx = 0; prev_cs = 1'b1; prev_sclk = 1'b0;
            have_gap = 1'b0; have_x = 1'b0; first_fall = 1'b1; spi_miso = 1'b0;
            exp_q.delete();
        end else begin
            if (prev_cs && !spi_cs_n) begin
                in_frame = 1'b1; fall_cyc = cyc; rises = 0; falls = 0;
                shreg = '0; period_bad = 1'b0;
                if (first_fall) chk("powerup_wait", cyc - rel_cyc, POWERUP);
                first_fall = 1'b0;
                if (have_gap) chk("cs_gap_min", 32'((cyc - rise_cyc) >= int'(CS_GAP)), 1);
                if (frame_idx == 0) chk("cfg_done_before_cfg", cfg_done, 0);
                if (frame_idx % 2 == 1) begin
                    if (have_x) chk("poll_period", cyc - x_fall_cyc, POLL);
                    have_x = 1'b1;
                    x_fall_cyc = cyc;
                end
            end
            if (!in_frame) spi_miso = miso_ones;
            if (in_frame && !prev_sclk && spi_sclk) begin
                rises++;
                shreg = {shreg[22:0], spi_mosi};
                if (rises == 1) period_bad = period_bad | ((cyc - fall_cyc) != int'(CLK_DIV));
                else            period_bad = period_bad | ((cyc - sclk_rise_cyc) != int'(2 * CLK_DIV));
                sclk_rise_cyc = cyc;
            end
            if (in_frame && prev_sclk && !spi_sclk) begin
                falls++;
                if (falls == 16) begin
                    if (miso_ones)               data = 8'hFF;
                    else if (shreg[7:0] == 8'h08) data = reg_x;
                    else if (shreg[7:0] == 8'h09) data = reg_y;
                    else                          data = 8'h00;
                    if (frame_idx % 2 == 1)       served_x = data;
                    else if (frame_idx > 0)       served_y = data;
                end
                if (falls >= 16 && falls <= 23) spi_miso = data[23 - falls];
                else                            spi_miso = miso_ones;
            end
            if (in_frame && !prev_cs && spi_cs_n) begin
                in_frame = 1'b0;
                chk("mosi_frame", shreg, exp_frame(frame_idx));
                chk("sclk_rises", rises, 24);
                chk("cs_low_cycles", cyc - fall_cyc, 48 * CLK_DIV);
                chk("sclk_timing_ok", period_bad, 0);
                if (frame_idx == 0) chk("cfg_done_after_cfg", cfg_done, 1);
                if (frame_idx > 0 && frame_idx % 2 == 0) exp_q.push_back({served_x, served_y});
                frame_idx++;
                frames_done++;
                rise_cyc = cyc;
                have_gap = 1'b1;
                spi_miso = miso_ones;
            end
            prev_cs   = spi_cs_n;
            prev_sclk = spi_sclk;
        end
    end

    // Output monitor: pops the scoreboard on every valid strobe
    logic [7:0]  prev_x = '0, prev_y = '0;
    logic        prev_v = 1'b0;
    logic [15:0] e;

    always @(negedge pixel_clk) begin
        if (!rst_n) begin
            prev_x = '0; prev_y = '0; prev_v = 1'b0;
        end else begin
            if (accel_valid) begin
                valid_cnt++;
                chk("valid_one_cycle", prev_v, 0);
                if (exp_q.size() == 0) begin
                    chk("unexpected_valid", accel_valid, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("accel_data_x", accel_data_x, e[15:8]);
                    chk("accel_data_y", accel_data_y, e[7:0]);
                end
            end else begin
                chk("data_hold", {accel_data_x, accel_data_y}, {prev_x, prev_y});
            end
            prev_x = accel_data_x;
            prev_y = accel_data_y;
            prev_v = accel_valid;
        end
    end

    task automatic wait_pairs(input int target);
        int n = 0;
        while (valid_cnt < target && n < 3 * POLL) begin
            @(negedge pixel_clk);
            n++;
        end
        if (valid_cnt < target) chk("valid_timeout", valid_cnt, target);
    endtask

    task automatic wait_frames(input int target);
        int n = 0;
        while (frames_done < target && n < 3 * POLL) begin
            @(negedge pixel_clk);
            n++;
        end
        if (frames_done < target) chk("frame_timeout", frames_done, target);
    endtask

    logic [7:0] old_x;
    logic       ps;
    int         nr;

    initial begin
        repeat (3) @(negedge pixel_clk);
        chk("rst_cs_n", spi_cs_n, 1);
        chk("rst_sclk", spi_sclk, 0);
        chk("rst_mosi", spi_mosi, 0);
        chk("rst_data", {accel_data_x, accel_data_y}, 0);
        chk("rst_valid", accel_valid, 0);
        chk("rst_cfg_done", cfg_done, 0);
        rel_cyc = cyc;
        rst_n = 1'b1;

        wait_pairs(1);
        chk("first_pair_x", accel_data_x, 8'h1F);
        chk("first_pair_y", accel_data_y, 8'hE3);

        for (int i = 0; i < 3; i++) begin
            reg_x = 8'($urandom);
            reg_y = 8'($urandom);
            wait_pairs(valid_cnt + 1);
        end

        // X register changes between the X and Y reads of one poll
        reg_x = 8'($urandom_range(0, 127));
        reg_y = 8'($urandom);
        old_x = reg_x;
        wait_frames(frames_done + 1);
        reg_x = 8'h80;
        wait_pairs(5);
        chk("midpoll_x_old", accel_data_x, old_x);
        wait_pairs(6);
        chk("midpoll_x_new", accel_data_x, 8'h80);

        miso_ones = 1'b1;
        wait_pairs(7);
        chk("ones_x", accel_data_x, 8'hFF);
        chk("ones_y", accel_data_y, 8'hFF);
        wait_pairs(8);
        miso_ones = 1'b0;

        // Reset on the 10th SCLK rise of the Y read
        nr = 0;
        while (!(in_frame && frame_idx > 0 && frame_idx % 2 == 0) && nr < 3 * POLL) begin
            @(negedge pixel_clk);
            nr++;
        end
        chk("reach_rd_y", in_frame, 1);
        nr = 0;
        ps = spi_sclk;
        for (int k = 0; k < 40 * int'(CLK_DIV) && nr < 10; k++) begin
            @(posedge pixel_clk);
            #1;
            if (spi_sclk && !ps) nr++;
            ps = spi_sclk;
        end
        chk("tenth_rise_seen", nr, 10);
        rst_n = 1'b0;
        #1;
        chk("async_cs_n", spi_cs_n, 1);
        chk("async_sclk", spi_sclk, 0);
        chk("async_mosi", spi_mosi, 0);
        chk("async_data", {accel_data_x, accel_data_y}, 0);
        chk("async_valid", accel_valid, 0);
        chk("async_cfg_done", cfg_done, 0);

        repeat (2) @(negedge pixel_clk);
        reg_x = 8'($urandom);
        reg_y = 8'($urandom);
        rel_cyc = cyc;
        rst_n = 1'b1;
        wait_pairs(9);

        repeat (10) @(negedge pixel_clk);
        chk("total_valid", valid_cnt, 9);
        chk("scoreboard_empty", exp_q.size(), 0);
        chk("cfg_done_final", cfg_done, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
